// File: rtl/rom_reader_pkg.sv
// rtl/rom_reader_pkg.sv - shared types and helpers for the ROM bank reader
package rom_reader_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Fixed-width bank field so the tag type is usable for any bank count up to 256.
    localparam int TAG_BANK_W = 8;

    typedef struct packed {
        logic                  valid;
        logic [TAG_BANK_W-1:0] bank;
        logic                  last;
    } rsp_tag_t;

    function automatic int bank_bits(input int num_banks);
        int b;
        b = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < num_banks) begin
                b = i + 1;
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/rom_rsp_pipe.sv
// rtl/rom_rsp_pipe.sv - response tag shift register matching the ROM read latency
module rom_rsp_pipe
    import rom_reader_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic     clk,
    input  logic     reset,
    input  rsp_tag_t in_tag,
    output rsp_tag_t out_tag,
    output logic     any_valid
);

    rsp_tag_t stage_q [LATENCY];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= in_tag;
            for (int i = 1; i < LATENCY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            any_valid = any_valid | stage_q[i].valid;
        end
    end

    assign out_tag = stage_q[LATENCY-1];

endmodule

// File: rtl/rom_bank_reader.sv
// rtl/rom_bank_reader.sv - multi-bank ROM read front-end with bursts and registered response
module rom_bank_reader
    import rom_reader_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 10,
    parameter int NUM_BANKS   = 2,
    parameter int BANK_BITS   = bank_bits(NUM_BANKS),
    parameter int LEN_WIDTH   = 4,
    parameter int ROM_LATENCY = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [BANK_BITS+ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]            req_len,
    input  logic                            req_wrap,
    output logic                            rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_data,
    output logic                            rsp_last,
    output logic                            busy,
    output logic [NUM_BANKS-1:0]            rom_cs,
    output logic [ADDR_WIDTH-1:0]           rom_addr,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0] rom_dout
);

    localparam int FULL_W = BANK_BITS + ADDR_WIDTH;

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic [FULL_W-1:0]     cur_addr_q, cur_addr_d;
    logic                  wrap_q, wrap_d;
    logic                  issue;
    logic                  issue_last;
    logic [FULL_W-1:0]     issue_addr;
    logic [BANK_BITS-1:0]  issue_bank;
    rsp_tag_t              in_tag, out_tag;
    logic                  any_valid;
    logic [DATA_WIDTH-1:0] sel_data;

    // Wrap mode keeps the bank bits and rolls only the in-macro address.
    function automatic logic [FULL_W-1:0] next_addr(input logic [FULL_W-1:0] a, input logic w);
        if (w) begin
            return {a[FULL_W-1 -: BANK_BITS], a[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1)};
        end
        return a + FULL_W'(1);
    endfunction

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        cur_addr_d  = cur_addr_q;
        wrap_d      = wrap_q;
        issue       = 1'b0;
        issue_last  = 1'b0;
        issue_addr  = cur_addr_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    issue       = 1'b1;
                    issue_addr  = req_addr;
                    issue_last  = (req_len == '0);
                    remaining_d = req_len;
                    cur_addr_d  = next_addr(req_addr, req_wrap);
                    wrap_d      = req_wrap;
                    if (req_len != '0) begin
                        state_d = BURST;
                    end
                end
            end
            BURST: begin
                issue       = 1'b1;
                issue_addr  = cur_addr_q;
                issue_last  = (remaining_q == LEN_WIDTH'(1));
                remaining_d = remaining_q - LEN_WIDTH'(1);
                cur_addr_d  = next_addr(cur_addr_q, wrap_q);
                if (issue_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign issue_bank = issue_addr[FULL_W-1 -: BANK_BITS];
    assign req_ready  = !reset && (state_q == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            cur_addr_q  <= '0;
            wrap_q      <= 1'b0;
            rom_cs      <= '0;
            rom_addr    <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            cur_addr_q  <= cur_addr_d;
            wrap_q      <= wrap_d;
            rom_cs      <= issue ? (NUM_BANKS'(1) << issue_bank) : '0;
            if (issue) begin
                rom_addr <= issue_addr[ADDR_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        in_tag       = '0;
        in_tag.valid = issue;
        in_tag.bank  = TAG_BANK_W'(issue_bank);
        in_tag.last  = issue_last;
    end

    rom_rsp_pipe #(
        .LATENCY (ROM_LATENCY)
    ) u_rsp_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_tag    (in_tag),
        .out_tag   (out_tag),
        .any_valid (any_valid)
    );

    always_comb begin
        sel_data = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (out_tag.bank == TAG_BANK_W'(b)) begin
                sel_data = rom_dout[b*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= out_tag.valid;
            rsp_last  <= out_tag.valid & out_tag.last;
            if (out_tag.valid) begin
                rsp_data <= sel_data;
            end
        end
    end

    assign busy = (state_q == BURST) || any_valid;

endmodule

// File: tb/tb_rom_bank_reader.sv
// tb/tb_rom_bank_reader.sv - scoreboard bench for rom_bank_reader with behavioural ROM model
module tb_rom_bank_reader;

    localparam int DW  = 8;
    localparam int AW  = 10;
    localparam int NB  = 2;
    localparam int BB  = 1;
    localparam int LW  = 4;
    localparam int LAT = 1;
    localparam int WORDS = 1 << AW;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic [BB+AW-1:0]   req_addr = '0;
    logic [LW-1:0]      req_len = '0;
    logic               req_wrap = 1'b0;
    logic               rsp_valid;
    logic [DW-1:0]      rsp_data;
    logic               rsp_last;
    logic               busy;
    logic [NB-1:0]      rom_cs;
    logic [AW-1:0]      rom_addr;
    logic [NB*DW-1:0]   rom_dout;

    rom_bank_reader #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .NUM_BANKS (NB),
        .LEN_WIDTH (LW), .ROM_LATENCY (LAT)
    ) dut (
        .clk (clk), .reset (reset), .req_valid (req_valid), .req_ready (req_ready),
        .req_addr (req_addr), .req_len (req_len), .req_wrap (req_wrap),
        .rsp_valid (rsp_valid), .rsp_data (rsp_data), .rsp_last (rsp_last),
        .busy (busy), .rom_cs (rom_cs), .rom_addr (rom_addr), .rom_dout (rom_dout)
    );

    always #5 clk = ~clk;

    // Macro model: data = low DW bits of bank*37 + addr, ROM_LATENCY edges after the address.
    logic [NB*DW-1:0] rom_comb;
    always_comb begin
        for (int b = 0; b < NB; b++) begin
            rom_comb[b*DW +: DW] = DW'(b * 37 + int'(rom_addr));
        end
    end
    generate
        if (LAT == 1) begin : g_lat1
            assign rom_dout = rom_comb;
        end else begin : g_latn
            logic [NB*DW-1:0] chain [LAT-1];
            always @(posedge clk) begin
                chain[0] <= rom_comb;
                for (int i = 1; i < LAT - 1; i++) chain[i] <= chain[i-1];
            end
            assign rom_dout = chain[LAT-2];
        end
    endgenerate

    typedef struct { int cyc; logic [NB-1:0] cs; logic [AW-1:0] addr; } iss_t;
    typedef struct { int cyc; logic [DW-1:0] data; logic last; } rsp_t;
    iss_t exp_iss [$];
    rsp_t exp_rsp [$];

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    endtask

    function automatic void word_of(input int a, input int i, input bit w, output int bank, output int low);
        if (w) begin
            bank = a / WORDS;
            low  = ((a % WORDS) + i) % WORDS;
        end else begin
            bank = ((a + i) % (NB * WORDS)) / WORDS;
            low  = (a + i) % WORDS;
        end
    endfunction

    // Issue-side monitor: every cycle either the scheduled read appears or rom_cs is zero.
    always @(negedge clk) begin
        if (!reset) begin
            while (exp_iss.size() > 0 && exp_iss[0].cyc < cyc) begin
                check("issue_missed", 32'(cyc), 32'(exp_iss[0].cyc));
                void'(exp_iss.pop_front());
            end
            if (exp_iss.size() > 0 && exp_iss[0].cyc == cyc) begin
                iss_t e;
                e = exp_iss.pop_front();
                check("rom_cs", 32'(rom_cs), 32'(e.cs));
                check("rom_addr", 32'(rom_addr), 32'(e.addr));
            end else if (rom_cs != '0) begin
                check("rom_cs_idle", 32'(rom_cs), 32'h0);
            end
        end
    end

    // Response monitor: data, last and exact cycle of every response word.
    always @(negedge clk) begin
        if (!reset) begin
            while (exp_rsp.size() > 0 && exp_rsp[0].cyc < cyc) begin
                check("rsp_missed", 32'(cyc), 32'(exp_rsp[0].cyc));
                void'(exp_rsp.pop_front());
            end
            if (exp_rsp.size() > 0 && exp_rsp[0].cyc == cyc) begin
                rsp_t e;
                e = exp_rsp.pop_front();
                check("rsp_valid", 32'(rsp_valid), 32'h1);
                check("rsp_data", 32'(rsp_data), 32'(e.data));
                check("rsp_last", 32'(rsp_last), 32'(e.last));
            end else if (rsp_valid) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'h0);
            end
        end
    end

    // Called at a negedge; returns at the negedge after acceptance with the accepting edge number.
    task automatic send(input int a, input int len, input bit w, output int acc);
        int waits;
        int bank, low;
        waits = 0;
        acc = -1;
        req_valid = 1'b1;
        req_addr  = (BB+AW)'(a);
        req_len   = LW'(len);
        req_wrap  = w;
        while (!req_ready && waits < 64) begin
            @(negedge clk);
            waits++;
        end
        if (!req_ready) begin
            check("accept_timeout", 32'(waits), 32'h0);
            req_valid = 1'b0;
        end else begin
            acc = cyc + 1;
            for (int i = 0; i <= len; i++) begin
                word_of(a, i, w, bank, low);
                exp_iss.push_back('{cyc: acc + i, cs: NB'(1 << bank), addr: AW'(low)});
                exp_rsp.push_back('{cyc: acc + i + LAT, data: DW'(bank * 37 + low), last: (i == len)});
            end
            @(negedge clk);
            req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int waits;
        waits = 0;
        while ((exp_iss.size() > 0 || exp_rsp.size() > 0) && waits < 64) begin
            @(negedge clk);
            waits++;
        end
        check("drain_timeout", 32'(exp_iss.size() + exp_rsp.size()), 32'h0);
        @(negedge clk);
        check("busy_idle", 32'(busy), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acc, acc2;
        int accs [4];
        repeat (3) @(negedge clk);
        check("ready_in_reset", 32'(req_ready), 32'h0);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_rom_cs", 32'(rom_cs), 32'h0);
        check("reset_rom_addr", 32'(rom_addr), 32'h0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_rsp_data", 32'(rsp_data), 32'h0);
        check("reset_rsp_last", 32'(rsp_last), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_ready", 32'(req_ready), 32'h1);

        send(11'h005, 0, 1'b0, acc);
        drain();
        send(11'h7FE, 3, 1'b1, acc);
        drain();
        send(11'h3FF, 1, 1'b0, acc);
        drain();
        send(11'h7FF, 1, 1'b0, acc);
        drain();

        for (int i = 0; i < 4; i++) send(i, 0, 1'b0, accs[i]);
        for (int i = 1; i < 4; i++) check("b2b_accept_edge", 32'(accs[i]), 32'(accs[0] + i));
        drain();

        send(11'h010, 3, 1'b0, acc);
        check("held_ready", 32'(req_ready), 32'h0);
        send(11'h421, 2, 1'b1, acc2);
        check("held_accept_edge", 32'(acc2), 32'(acc + 4));
        drain();

        send(11'h020, 7, 1'b0, acc);
        @(negedge clk);
        #1 reset = 1'b1;
        exp_iss.delete();
        exp_rsp.delete();
        @(negedge clk);
        check("midrst_rom_cs", 32'(rom_cs), 32'h0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("midrst_ready", 32'(req_ready), 32'h0);
        #1 reset = 1'b0;
        #1 check("postrst_ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        check("postrst_busy", 32'(busy), 32'h0);
        check("postrst_rsp_valid", 32'(rsp_valid), 32'h0);
        repeat (10) @(negedge clk);

        for (int n = 0; n < 40; n++) begin
            int a, len;
            bit w;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            a = $urandom_range(0, NB * WORDS - 1);
            if ($urandom_range(0, 3) == 0) a = ($urandom_range(0, 1) ? 2 * WORDS - 4 : WORDS - 4) + $urandom_range(0, 3);
            len = $urandom_range(0, 6);
            w = 1'($urandom_range(0, 1));
            send(a, len, w, acc);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
